// File: rtl/spike_enc_pkg.sv
// Shared types and default sizing for the spike rate encoder.
package spike_enc_pkg;
  localparam int SPK_INPUTS = 8;
  localparam int SPK_WIDTH  = 8;
  localparam int SPK_ADDR_W = 3;
  localparam int SPK_DIV_W  = 8;
  localparam int SPK_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/spike_rate_lane.sv
// One sigma-delta lane: WIDTH-bit phase accumulator, spike is the carry-out
// of acc+intensity (combinational; the top registers it on a tick).
module spike_rate_lane
  import spike_enc_pkg::*;
#(
  parameter int WIDTH = SPK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [WIDTH-1:0] intensity,
  output logic             spike
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, intensity};
  assign spike = sum[WIDTH];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (tick) begin
      acc <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes INPUTS intensities into one spike vector per timestep (tick every
// step_div+1 cycles); x/x_valid update the cycle after a tick, done ends a frame.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int INPUTS = SPK_INPUTS,
  parameter int WIDTH  = SPK_WIDTH,
  parameter int ADDR_W = SPK_ADDR_W,
  parameter int DIV_W  = SPK_DIV_W,
  parameter int LEN_W  = SPK_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              start,
  input  logic              abort,
  output logic [INPUTS-1:0] x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   pre;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   step_cnt;
  logic [INPUTS-1:0]  spk;
  logic               clr;
  logic               tick;

  assign clr  = (state == IDLE) && start && !abort;
  assign tick = (state == RUN) && !abort && (pre == '0);
  assign busy = (state == RUN);

  // Addresses at or above INPUTS match no lane, so such writes fall away.
  for (genvar i = 0; i < INPUTS; i++) begin : g_lane
    logic [WIDTH-1:0] intensity;

    always_ff @(posedge clk) begin
      if (reset) begin
        intensity <= '0;
      end else if (cfg_we && cfg_addr == ADDR_W'(i)) begin
        intensity <= cfg_data;
      end
    end

    spike_rate_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .tick      (tick),
      .intensity (intensity),
      .spike     (spk[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= '0;
      pre      <= '0;
      len_q    <= '0;
      step_cnt <= '0;
      x        <= '0;
      x_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      x_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            div_q    <= step_div;
            len_q    <= frame_len;
            pre      <= step_div;
            step_cnt <= '0;
            x        <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            x     <= '0;
            state <= IDLE;
          end else if (pre == '0) begin
            pre      <= div_q;
            x        <= spk;
            x_valid  <= 1'b1;
            step_cnt <= step_cnt + LEN_W'(1);
            // frame_len of zero never matches here, which gives free-run.
            if (len_q != '0 && step_cnt + LEN_W'(1) == len_q) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            pre <= pre - DIV_W'(1);
          end
        end
        DONE: begin
          if (abort) begin
            x <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
